// File: rtl/scan_tap_ctrl.sv
// scan_tap_ctrl: IEEE 1149.1-style TAP controller for the DFT-wrapped s9234 core.
// Decodes TMS into the 16-state TAP FSM, holds the instruction register, and routes
// TDI/TDO through the bypass register, the optional IDCODE register or the core scan
// chain. It also drives the core scan-enable, clock-enable and test-mode controls.
//
// Optional feature: define IDCODE_EN to include the 32-bit IDCODE register. When
// IDCODE_EN is defined, OP_IDCODE selects IDCODE and is the reset instruction.
// Otherwise OP_IDCODE decodes as BYPASS and OP_BYPASS is the reset instruction.
//
// Ports:
//   TCK        in   sole clock, rising edge
//   TRST       in   synchronous active-high reset
//   TMS        in   test mode select
//   TDI        in   serial test data in
//   TDO        out  serial test data out (combinational)
//   scan_out   in   last flop of the core scan chain
//   scan_in    out  first flop of the core scan chain (mirrors TDI)
//   scan_en    out  core scan-enable
//   core_ce    out  core flop clock enable
//   mode       out  core test mode (active instruction is OP_SCAN)
//   tap_state  out  current FSM state
//   ir_active  out  current active instruction
module scan_tap_ctrl #(
  parameter int unsigned         IR_WIDTH     = 3,
  parameter logic [31:0]         IDCODE_VALUE = 32'h1923_4001,
  parameter logic [IR_WIDTH-1:0] OP_IDCODE    = 3'b001,
  parameter logic [IR_WIDTH-1:0] OP_SCAN      = 3'b010,
  parameter logic [IR_WIDTH-1:0] OP_BYPASS    = 3'b111
) (
  input  logic                TCK,
  input  logic                TRST,
  input  logic                TMS,
  input  logic                TDI,
  output logic                TDO,
  input  logic                scan_out,
  output logic                scan_in,
  output logic                scan_en,
  output logic                core_ce,
  output logic                mode,
  output logic [3:0]          tap_state,
  output logic [IR_WIDTH-1:0] ir_active
);

  typedef enum logic [3:0] {
    StTlr   = 4'hF,
    StRti   = 4'hC,
    StSelDr = 4'h7,
    StCapDr = 4'h6,
    StShDr  = 4'h2,
    StEx1Dr = 4'h1,
    StPauDr = 4'h3,
    StEx2Dr = 4'h0,
    StUpdDr = 4'h5,
    StSelIr = 4'h4,
    StCapIr = 4'hE,
    StShIr  = 4'hA,
    StEx1Ir = 4'h9,
    StPauIr = 4'hB,
    StEx2Ir = 4'h8,
    StUpdIr = 4'hD
  } tap_state_e;

  // Fixed 01 in the two LSBs of the captured IR, as the standard requires.
  localparam logic [IR_WIDTH-1:0] IrCapture = IR_WIDTH'(2'b01);

`ifdef IDCODE_EN
  localparam logic [IR_WIDTH-1:0] RstIr = OP_IDCODE;
`else
  localparam logic [IR_WIDTH-1:0] RstIr = OP_BYPASS;
`endif

  tap_state_e          state_q, state_d;
  logic [IR_WIDTH-1:0] ir_sr_q;
  logic [IR_WIDTH-1:0] ir_active_q;
  logic                bypass_q;
  logic                sel_scan;
  logic                sel_bypass;

`ifdef IDCODE_EN
  logic [31:0] idcode_q;
  logic        sel_idcode;

  assign sel_idcode = (ir_active_q == OP_IDCODE);
  assign sel_scan   = (ir_active_q == OP_SCAN);
  assign sel_bypass = !sel_scan && !sel_idcode;
`else
  // IDCODE register is absent; keep its parameters referenced for lint.
  logic unused_idcode_params;

  assign unused_idcode_params = ^{IDCODE_VALUE, OP_IDCODE};
  assign sel_scan   = (ir_active_q == OP_SCAN);
  assign sel_bypass = !sel_scan;
`endif

  // Next-state decode of the TAP FSM.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StTlr:   state_d = TMS ? StTlr   : StRti;
      StRti:   state_d = TMS ? StSelDr : StRti;
      StSelDr: state_d = TMS ? StSelIr : StCapDr;
      StCapDr: state_d = TMS ? StEx1Dr : StShDr;
      StShDr:  state_d = TMS ? StEx1Dr : StShDr;
      StEx1Dr: state_d = TMS ? StUpdDr : StPauDr;
      StPauDr: state_d = TMS ? StEx2Dr : StPauDr;
      StEx2Dr: state_d = TMS ? StUpdDr : StShDr;
      StUpdDr: state_d = TMS ? StSelDr : StRti;
      StSelIr: state_d = TMS ? StTlr   : StCapIr;
      StCapIr: state_d = TMS ? StEx1Ir : StShIr;
      StShIr:  state_d = TMS ? StEx1Ir : StShIr;
      StEx1Ir: state_d = TMS ? StUpdIr : StPauIr;
      StPauIr: state_d = TMS ? StEx2Ir : StPauIr;
      StEx2Ir: state_d = TMS ? StUpdIr : StShIr;
      StUpdIr: state_d = TMS ? StSelDr : StRti;
      default: state_d = StTlr;
    endcase
  end

  // FSM state, IR and data registers. Reset leaves the shift registers untouched.
  always_ff @(posedge TCK) begin
    if (TRST) begin
      state_q     <= StTlr;
      ir_active_q <= RstIr;
    end else begin
      state_q <= state_d;
      case (state_q)
        StTlr:   ir_active_q <= RstIr;
        StCapIr: ir_sr_q     <= IrCapture;
        StShIr:  ir_sr_q     <= {TDI, ir_sr_q[IR_WIDTH-1:1]};
        StUpdIr: ir_active_q <= ir_sr_q;
        StCapDr: begin
          if (sel_bypass) bypass_q <= 1'b0;
`ifdef IDCODE_EN
          if (sel_idcode) idcode_q <= IDCODE_VALUE;
`endif
        end
        StShDr: begin
          if (sel_bypass) bypass_q <= TDI;
`ifdef IDCODE_EN
          if (sel_idcode) idcode_q <= {TDI, idcode_q[31:1]};
`endif
        end
        default: ;
      endcase
    end
  end

  // Serial output mux; only the two shift states drive data.
  always_comb begin
    TDO = 1'b0;
    if (state_q == StShIr) begin
      TDO = ir_sr_q[0];
    end else if (state_q == StShDr) begin
      if (sel_scan) begin
        TDO = scan_out;
`ifdef IDCODE_EN
      end else if (sel_idcode) begin
        TDO = idcode_q[0];
`endif
      end else begin
        TDO = bypass_q;
      end
    end
  end

  // Core control: capture on CAP_DR, shift on SH_DR, hold everywhere else.
  // UPD_IR is never SH_DR, so an instruction change cannot glitch scan_en.
  assign mode      = sel_scan;
  assign scan_en   = sel_scan && (state_q == StShDr);
  assign core_ce   = sel_scan && ((state_q == StShDr) || (state_q == StCapDr));
  assign scan_in   = TDI;
  assign tap_state = state_q;
  assign ir_active = ir_active_q;

endmodule

// File: tb/tb_scan_tap_ctrl.sv
module tb_scan_tap_ctrl;

  localparam logic [2:0] OpIdcode = 3'b001;
  localparam logic [2:0] OpScan   = 3'b010;
  localparam logic [2:0] OpBypass = 3'b111;
`ifdef IDCODE_EN
  localparam logic [2:0] RstIr = OpIdcode;
`else
  localparam logic [2:0] RstIr = OpBypass;
`endif

  logic       TCK = 1'b0;
  logic       TRST, TMS, TDI, TDO;
  logic       scan_out, scan_in, scan_en, core_ce, mode;
  logic [3:0] tap_state;
  logic [2:0] ir_active;

  int checks = 0;
  int errors = 0;

  always #5 TCK = ~TCK;

  scan_tap_ctrl dut (
    .TCK       (TCK),
    .TRST      (TRST),
    .TMS       (TMS),
    .TDI       (TDI),
    .TDO       (TDO),
    .scan_out  (scan_out),
    .scan_in   (scan_in),
    .scan_en   (scan_en),
    .core_ce   (core_ce),
    .mode      (mode),
    .tap_state (tap_state),
    .ir_active (ir_active)
  );

  // Drive one TCK edge; outputs settle 1 time unit after the edge.
  task automatic tick(input logic tms, input logic tdi);
    TMS = tms;
    TDI = tdi;
    @(posedge TCK);
    #1;
  endtask

  // Load an instruction from RTI, returning to RTI (stimulus only).
  task automatic load_ir(input logic [2:0] op);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, op[0]);
    tick(1'b0, op[1]);
    tick(1'b1, op[2]);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    TRST = 1'b1;
    tick(1'b0, 1'b0);
    TRST = 1'b0;
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    checks++;
    if (tap_state !== 4'h2) begin
      errors++;
      $display("FAIL reset_pre_shdr: got %h expected %h", tap_state, 4'h2);
    end
    // TMS=0 in SH_DR would stay; reset must win.
    TRST = 1'b1;
    tick(1'b0, 1'b0);
    TRST = 1'b0;
    checks++;
    if (tap_state !== 4'hF) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", tap_state, 4'hF);
    end
    checks++;
    if (scan_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_scan_en: got %b expected 0", scan_en);
    end
    checks++;
    if (core_ce !== 1'b0) begin
      errors++;
      $display("FAIL reset_core_ce: got %b expected 0", core_ce);
    end
    checks++;
    if (mode !== 1'b0) begin
      errors++;
      $display("FAIL reset_mode: got %b expected 0", mode);
    end
    checks++;
    if (ir_active !== RstIr) begin
      errors++;
      $display("FAIL reset_ir_active: got %b expected %b", ir_active, RstIr);
    end
    checks++;
    if (TDO !== 1'b0) begin
      errors++;
      $display("FAIL reset_tdo: got %b expected 0", TDO);
    end
  endtask

  task automatic test_tms_walk();
    logic [6:0] tms_pat = 7'b0110001;
    logic [3:0] exp_st [7] = '{4'h7, 4'h6, 4'h2, 4'h2, 4'h1, 4'h5, 4'hC};
    logic [4:0] pau_pat = 5'b01011;
    logic [3:0] pau_st [5] = '{4'h7, 4'h4, 4'hE, 4'h9, 4'hB};
    logic [3:0] tlr_st [5] = '{4'h8, 4'hD, 4'h7, 4'h4, 4'hF};
    tick(1'b1, 1'b0);
    checks++;
    if (tap_state !== 4'hF) begin
      errors++;
      $display("FAIL walk_tlr_hold: got %h expected %h", tap_state, 4'hF);
    end
    tick(1'b0, 1'b0);
    checks++;
    if (tap_state !== 4'hC) begin
      errors++;
      $display("FAIL walk_rti: got %h expected %h", tap_state, 4'hC);
    end
    for (int i = 0; i < 7; i++) begin
      tick(tms_pat[i], 1'b0);
      checks++;
      if (tap_state !== exp_st[i]) begin
        errors++;
        $display("FAIL walk_step%0d: got %h expected %h", i, tap_state, exp_st[i]);
      end
    end
    for (int i = 0; i < 5; i++) begin
      tick(pau_pat[i], 1'b0);
      checks++;
      if (tap_state !== pau_st[i]) begin
        errors++;
        $display("FAIL walk_to_pauir%0d: got %h expected %h", i, tap_state, pau_st[i]);
      end
    end
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b0);
      checks++;
      if (tap_state !== tlr_st[i]) begin
        errors++;
        $display("FAIL walk_tms5_%0d: got %h expected %h", i, tap_state, tlr_st[i]);
      end
    end
    // UPD_IR loaded the captured 001; one edge in TLR restores the reset instruction.
    checks++;
    if (ir_active !== 3'b001) begin
      errors++;
      $display("FAIL walk_upd_ir: got %b expected %b", ir_active, 3'b001);
    end
    tick(1'b1, 1'b0);
    checks++;
    if (ir_active !== RstIr) begin
      errors++;
      $display("FAIL walk_tlr_reload: got %b expected %b", ir_active, RstIr);
    end
  endtask

  // DR scan straight after reset: IDCODE when enabled, bypass otherwise.
  task automatic test_reset_dr_scan();
`ifdef IDCODE_EN
    logic [31:0] exp_id = 32'h1923_4001;
`else
    logic [2:0] tdi_pat = 3'b001;
    logic [2:0] exp_tdo = 3'b010;
`endif
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
`ifdef IDCODE_EN
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (TDO !== exp_id[i]) begin
        errors++;
        $display("FAIL idcode_bit%0d: got %b expected %b", i, TDO, exp_id[i]);
      end
      tick(i == 31, 1'b0);
    end
`else
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (TDO !== exp_tdo[i]) begin
        errors++;
        $display("FAIL reset_bypass_bit%0d: got %b expected %b", i, TDO, exp_tdo[i]);
      end
      tick(i == 2, tdi_pat[i]);
    end
`endif
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    checks++;
    if (tap_state !== 4'hC) begin
      errors++;
      $display("FAIL reset_scan_rti: got %h expected %h", tap_state, 4'hC);
    end
  endtask

  task automatic test_ir_path();
    logic [2:0] tdi_pat = 3'b010;
    logic [2:0] exp_tdo = 3'b001;
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (TDO !== exp_tdo[i]) begin
        errors++;
        $display("FAIL ir_capture_bit%0d: got %b expected %b", i, TDO, exp_tdo[i]);
      end
      tick(i == 2, tdi_pat[i]);
    end
    tick(1'b1, 1'b0);
    checks++;
    if (ir_active !== RstIr) begin
      errors++;
      $display("FAIL ir_before_update: got %b expected %b", ir_active, RstIr);
    end
    tick(1'b0, 1'b0);
    checks++;
    if (ir_active !== OpScan) begin
      errors++;
      $display("FAIL ir_after_update: got %b expected %b", ir_active, OpScan);
    end
    checks++;
    if (mode !== 1'b1) begin
      errors++;
      $display("FAIL ir_mode: got %b expected 1", mode);
    end
  endtask

  task automatic test_scan();
    int  ce_cnt = 0;
    int  se_cnt = 0;
    logic tms, exp_ce, exp_se, exp_tdo;
    for (int k = 0; k < 237; k++) begin
      tms      = (k == 0) || (k == 230) || (k == 234) || (k == 235);
      exp_ce   = (k >= 2) && (k <= 230);
      exp_se   = (k >= 3) && (k <= 230);
      TMS      = tms;
      TDI      = k[1] ^ k[3];
      scan_out = k[0] ^ k[2];
      exp_tdo  = exp_se ? scan_out : 1'b0;
      #1;
      if (core_ce === 1'b1) ce_cnt++;
      if (scan_en === 1'b1) se_cnt++;
      checks++;
      if (core_ce !== exp_ce) begin
        errors++;
        $display("FAIL scan_core_ce_k%0d: got %b expected %b", k, core_ce, exp_ce);
      end
      checks++;
      if (scan_en !== exp_se) begin
        errors++;
        $display("FAIL scan_en_k%0d: got %b expected %b", k, scan_en, exp_se);
      end
      checks++;
      if (scan_in !== TDI) begin
        errors++;
        $display("FAIL scan_in_k%0d: got %b expected %b", k, scan_in, TDI);
      end
      checks++;
      if (TDO !== exp_tdo) begin
        errors++;
        $display("FAIL scan_tdo_k%0d: got %b expected %b", k, TDO, exp_tdo);
      end
      @(posedge TCK);
      #1;
    end
    checks++;
    if (ce_cnt != 229) begin
      errors++;
      $display("FAIL scan_ce_count: got %0d expected 229", ce_cnt);
    end
    checks++;
    if (se_cnt != 228) begin
      errors++;
      $display("FAIL scan_en_count: got %0d expected 228", se_cnt);
    end
    checks++;
    if (tap_state !== 4'hC) begin
      errors++;
      $display("FAIL scan_end_state: got %h expected %h", tap_state, 4'hC);
    end
    scan_out = 1'b0;
  endtask

  // DR scan from RTI with TDI 1,0,1,1; returns to RTI.
  task automatic dr_scan_check(input string name, input logic [3:0] exp_tdo);
    logic [3:0] tdi_pat = 4'b1101;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (TDO !== exp_tdo[i]) begin
        errors++;
        $display("FAIL %s_bit%0d: got %b expected %b", name, i, TDO, exp_tdo[i]);
      end
      checks++;
      if (scan_en !== 1'b0) begin
        errors++;
        $display("FAIL %s_scan_en%0d: got %b expected 0", name, i, scan_en);
      end
      tick(i == 3, tdi_pat[i]);
    end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  task automatic test_bypass();
    load_ir(OpBypass);
    checks++;
    if (ir_active !== OpBypass) begin
      errors++;
      $display("FAIL bypass_ir: got %b expected %b", ir_active, OpBypass);
    end
    checks++;
    if (mode !== 1'b0) begin
      errors++;
      $display("FAIL bypass_mode: got %b expected 0", mode);
    end
    dr_scan_check("bypass", 4'b1010);
  endtask

  task automatic test_back_to_back();
    load_ir(OpIdcode);
    checks++;
    if (ir_active !== OpIdcode) begin
      errors++;
      $display("FAIL idop_ir: got %b expected %b", ir_active, OpIdcode);
    end
`ifdef IDCODE_EN
    dr_scan_check("idop", 4'b0001);
`else
    dr_scan_check("idop", 4'b1010);
`endif
  endtask

  initial begin
    TRST     = 1'b1;
    TMS      = 1'b1;
    TDI      = 1'b0;
    scan_out = 1'b0;
    test_reset();
    test_tms_walk();
    test_reset_dr_scan();
    test_ir_path();
    test_scan();
    test_bypass();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
